// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: funct3 codes,
// opcode fields, sequencer state encoding and an operand magnitude helper.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-to-sequencer bus: M-op request from EX and the stall/result return path.
interface muldiv_sequencer_if;
    import riscv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, flush,
        output stall, busy, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the shared 65-bit accumulator {carry/rem-sign, hi, lo}.
module muldiv_step
    import riscv_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_out,
    output logic              q_bit
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Single multiply or divide iteration selected by mode.
    always_comb begin
        sum_s     = {(XLEN+1){1'b0}};
        shifted_s = {(XLEN+1){1'b0}};
        diff_s    = {(XLEN+1){1'b0}};
        q_bit     = 1'b0;
        acc_out   = acc_in;
        if (is_div) begin
            // Remainder lives in the high half, dividend/quotient in the low half.
            shifted_s = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
            diff_s    = shifted_s - {1'b0, operand};
            q_bit     = ~diff_s[XLEN];
            acc_out   = {(q_bit ? diff_s : shifted_s), acc_in[XLEN-2:0], q_bit};
        end else begin
            sum_s   = acc_in[2*XLEN:XLEN] + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
            acc_out = {1'b0, sum_s, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller for the EX stage: latches operand
// magnitudes and sign, runs 32 iterations, fixes the sign and presents the result.
module muldiv_sequencer
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic [4:0]        cnt_r;
    logic [2:0]        f3_r;
    logic              neg_r;
    logic [XLEN-1:0]   operand_r;
    logic [2*XLEN:0]   acc_r;
    logic [XLEN-1:0]   result_r;
    logic              busy_r;
    logic              done_r;
    logic              stall_s;

    logic              in_div_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              div0_s;
    logic              ovf_s;
    logic              special_s;
    logic              neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN-1:0]   special_res_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res_s;
    logic [2*XLEN:0]   step_acc_s;
    logic              step_q_s;

    muldiv_step u_step (
        .is_div  (f3_r[2]),
        .acc_in  (acc_r),
        .operand (operand_r),
        .acc_out (step_acc_s),
        .q_bit   (step_q_s)
    );

    // Request decode: signedness, special divides and latched result sign.
    always_comb begin
        in_div_s   = bus.funct3[2];
        a_signed_s = in_div_s ? ~bus.funct3[0]
                              : ((bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU));
        b_signed_s = in_div_s ? ~bus.funct3[0] : (bus.funct3 == F3_MULH);
        div0_s     = in_div_s && (bus.rs2_val == 32'h0000_0000);
        ovf_s      = in_div_s && ~bus.funct3[0] && (bus.rs1_val == 32'h8000_0000)
                     && (bus.rs2_val == 32'hFFFF_FFFF);
        special_s  = div0_s || ovf_s;
        a_mag_s    = abs_val(bus.rs1_val, a_signed_s);
        b_mag_s    = abs_val(bus.rs2_val, b_signed_s);
        // Remainder follows the dividend sign only; everything else XORs both.
        if (in_div_s && bus.funct3[1]) begin
            neg_s = a_signed_s && bus.rs1_val[XLEN-1];
        end else begin
            neg_s = (a_signed_s && bus.rs1_val[XLEN-1]) ^ (b_signed_s && bus.rs2_val[XLEN-1]);
        end
        if (div0_s) begin
            special_res_s = bus.funct3[1] ? bus.rs1_val : 32'hFFFF_FFFF;
        end else begin
            special_res_s = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // Sign fix and output select applied in FIX.
    always_comb begin
        prod_s = neg_r ? (~acc_r[2*XLEN-1:0] + 64'd1) : acc_r[2*XLEN-1:0];
        case (f3_r)
            F3_MUL:                      fix_res_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_res_s = neg_r ? (~acc_r[XLEN-1:0] + 32'd1)
                                                           : acc_r[XLEN-1:0];
            F3_REM, F3_REMU:             fix_res_s = neg_r ? (~acc_r[2*XLEN-1:XLEN] + 32'd1)
                                                           : acc_r[2*XLEN-1:XLEN];
            default:                     fix_res_s = 32'h0000_0000;
        endcase
    end

    // FSM next-state; flush wins over start and over the final iteration.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.flush)      state_s = IDLE;
                else if (bus.start) state_s = special_s ? DONE : CALC;
                else                state_s = IDLE;
            end
            CALC: begin
                if (bus.flush)              state_s = IDLE;
                else if (cnt_r == 5'd0)     state_s = FIX;
                else                        state_s = CALC;
            end
            FIX: begin
                if (bus.flush) state_s = IDLE;
                else           state_s = DONE;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs; stall is the only combinational output.
    always_comb begin
        stall_s = ~bus.flush && (((state_r == IDLE) && bus.start)
                                 || (state_r == CALC) || (state_r == FIX));
    end

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == CALC) || (state_s == FIX);
            done_r  <= (state_s == DONE);
        end
    end

    // Datapath: operand/sign latch, iteration, counter and result write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= 5'd0;
            f3_r      <= 3'd0;
            neg_r     <= 1'b0;
            operand_r <= 32'h0000_0000;
            acc_r     <= 65'd0;
            result_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        f3_r      <= bus.funct3;
                        neg_r     <= neg_s;
                        cnt_r     <= 5'd31;
                        operand_r <= in_div_s ? b_mag_s : a_mag_s;
                        acc_r     <= {33'd0, (in_div_s ? a_mag_s : b_mag_s)};
                        if (special_s) begin
                            result_r <= special_res_s;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc_r <= step_acc_s;
                        cnt_r <= (cnt_r == 5'd0) ? 5'd0 : (cnt_r - 5'd1);
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        result_r <= fix_res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.stall  = stall_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: multiply/divide results,
// latency, stall length, special divides, flush, mid-op reset and back-to-back ops.
module tb_muldiv_sequencer;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drives one op from the current cycle (k=0) and waits for done.
    // stall_cnt counts stall cycles after the start cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stall_cnt, output logic stall0,
                          output logic done0, output logic [31:0] res);
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.start   = 1'b1;
        lat         = -1;
        stall_cnt   = 0;
        stall0      = 1'b0;
        done0       = 1'b0;
        res         = 32'h0000_0000;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                stall0 = bus.stall;
                done0  = bus.done;
            end
            if ((k > 0) && bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
            if ((k > 0) && bus.stall) stall_cnt++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_mul();
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, lat, sc, s0, d0, res);
        bus.start = 1'b0;
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected %h", res, 32'hFFFF_FFEB); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d expected 34", lat); end
        n_checks++; if (sc !== 33) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 33", sc); end
        n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL mul_stall_start_cycle: got %b expected 1", s0); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse_width: got %b expected 0", bus.done); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mulh_variants();
        logic [2:0]  f3s [3] = '{F3_MULH, F3_MULHU, F3_MULHSU};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, sc, s0, d0, res);
            bus.start = 1'b0;
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL mulh_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mulh_latency[%0d]: got %0d expected 34", i, lat); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_divide();
        logic [2:0]  f3s [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, sc, s0, d0, res);
            bus.start = 1'b0;
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_special_div();
        logic [2:0]  f3s [4] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM};
        logic [31:0] as  [4] = '{32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0};
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, sc, s0, d0, res);
            bus.start = 1'b0;
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
            n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL special_stall_start[%0d]: got %b expected 1", i, s0); end
            n_checks++; if (sc !== 0) begin n_fail++; $display("FAIL special_stall_after[%0d]: got %0d expected 0", i, sc); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        int lat, sc, done_seen;
        logic s0, d0;
        logic [31:0] res;
        run_op(F3_REMU, 32'd100, 32'd7, lat, sc, s0, d0, res);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.funct3  = F3_DIVU;
        bus.rs1_val = 32'd100;
        bus.rs2_val = 32'd7;
        bus.start   = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_same_cycle: got %b expected 0", bus.stall); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", bus.busy); end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b expected 0", bus.busy); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_after: got %b expected 0", bus.stall); end
        n_checks++; if (bus.result !== 32'd2) begin n_fail++; $display("FAIL flush_result_hold: got %h expected %h", bus.result, 32'd2); end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", done_seen); end
        @(posedge clk);
        #1;
        run_op(F3_DIVU, 32'd100, 32'd7, lat, sc, s0, d0, res);
        bus.start = 1'b0;
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL flush_restart_result: got %h expected %h", res, 32'd14); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL flush_restart_latency: got %0d expected 34", lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        bus.funct3  = F3_MUL;
        bus.rs1_val = 32'd7;
        bus.rs2_val = 32'hFFFF_FFFD;
        bus.start   = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", bus.busy); end
        #2;
        reset     = 1'b0;
        bus.start = 1'b0;
        #1;
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected %h", bus.result, 32'h0); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b expected 0", bus.stall); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(F3_MUL, 32'd3, 32'd5, lat, sc, s0, d0, res);
        bus.start = 1'b0;
        n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL midreset_mul_result: got %h expected %h", res, 32'd15); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL midreset_mul_latency: got %0d expected 34", lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, sc;
        logic s0, d0;
        logic [31:0] res;
        run_op(F3_DIVU, 32'd100, 32'd7, lat, sc, s0, d0, res);
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", res, 32'd14); end
        run_op(F3_REMU, 32'd100, 32'd7, lat, sc, s0, d0, res);
        bus.start = 1'b0;
        n_checks++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done: got %b expected 0", d0); end
        n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall: got %b expected 1", s0); end
        n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'd2); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        clk         = 1'b0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct3  = 3'd0;
        bus.rs1_val = 32'h0;
        bus.rs2_val = 32'h0;
        test_reset();
        @(posedge clk);
        #1;
        test_mul();
        test_mulh_variants();
        test_divide();
        test_special_div();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
